// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the shared-bus arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package bus_arbiter_pkg;

  // Arbiter state encoding, shared by the top level and the bench.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANTED = 2'd1,
    ST_ABORT   = 2'd2
  } arb_state_t;

  // Master index width: sized for the largest supported bus (8 masters).
  localparam int OWNER_W = 3;

  // Watchdog counter width.
  localparam int WD_W = 16;

endpackage : bus_arbiter_pkg

// File: rtl/bus_arbiter_if.sv
// Bundle of request/grant and shared bus-strobe signals seen by the arbiter.
// Latency: none (wires only).
// Backpressure: masters hold req as a level until they are granted.
interface bus_arbiter_if #(
  parameter int N_MASTERS = 4
);
  import bus_arbiter_pkg::*;

  logic [N_MASTERS-1:0] req;
  logic [N_MASTERS-1:0] grant;
  logic                 rd_bus;
  logic                 wr_bus;
  logic                 fc_bus;
  logic                 fc_timeout;
  logic                 err;
  logic [OWNER_W-1:0]   err_master;
  logic                 err_clr;

  // System side: masters, bus strobes and the error-clear pulse.
  modport master (
    output req, rd_bus, wr_bus, fc_bus, err_clr,
    input  grant, fc_timeout, err, err_master
  );

  // Arbiter side.
  modport slave (
    input  req, rd_bus, wr_bus, fc_bus, err_clr,
    output grant, fc_timeout, err, err_master
  );

endinterface : bus_arbiter_if

// File: rtl/bus_arbiter_rr_picker.sv
// Round-robin picker: first requester strictly after last_owner, wrapping.
// Latency: combinational.
// Backpressure: none; found=0 when no request is pending.
module bus_arbiter_rr_picker
  import bus_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 4
) (
  input  logic [N_MASTERS-1:0] i_req,
  input  logic [OWNER_W-1:0]   i_last_owner,
  output logic                 o_found,
  output logic [OWNER_W-1:0]   o_index
);

  // Pass one scans above last_owner, pass two wraps to 0..last_owner.
  always_comb begin
    o_found = 1'b0;
    o_index = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (!o_found && i_req[i] && (i > int'(i_last_owner))) begin
        o_found = 1'b1;
        o_index = OWNER_W'(i);
      end
    end
    for (int i = 0; i < N_MASTERS; i++) begin
      if (!o_found && i_req[i] && (i <= int'(i_last_owner))) begin
        o_found = 1'b1;
        o_index = OWNER_W'(i);
      end
    end
  end

endmodule : bus_arbiter_rr_picker

// File: rtl/bus_arbiter.sv
// Round-robin shared-bus arbiter with transfer watchdog and sticky timeout error.
// Latency: grant one cycle after req sampled; one idle turnaround cycle after each release.
// Backpressure: grant is never revoked while rd/wr is active; stuck transfers are completed via fc_timeout.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int N_MASTERS      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic           clk,
  input logic           rst,
  bus_arbiter_if.slave  bus
);

  arb_state_t           r_state;
  arb_state_t           w_state_nxt;
  logic [N_MASTERS-1:0] r_grant;
  logic [N_MASTERS-1:0] w_grant_nxt;
  logic [OWNER_W-1:0]   r_owner;
  logic [OWNER_W-1:0]   w_owner_nxt;
  logic [OWNER_W-1:0]   r_last_owner;
  logic [OWNER_W-1:0]   w_last_owner_nxt;
  logic [WD_W-1:0]      r_wd;
  logic [WD_W-1:0]      w_wd_nxt;
  logic [WD_W-1:0]      w_wd_inc;
  logic                 r_err;
  logic [OWNER_W-1:0]   r_err_master;

  logic                 w_active;
  logic                 w_owner_req;
  logic                 w_expire;
  logic                 w_abort_set;
  logic                 w_pick_found;
  logic [OWNER_W-1:0]   w_pick_idx;

  // Grant is one-hot on the owner, so masking req by it yields req[owner].
  assign w_active    = bus.rd_bus | bus.wr_bus;
  assign w_owner_req = |(bus.req & r_grant);
  assign w_wd_inc    = r_wd + WD_W'(1);
  assign w_expire    = (w_wd_inc == WD_W'(TIMEOUT_CYCLES));

  bus_arbiter_rr_picker #(
    .N_MASTERS (N_MASTERS)
  ) u_rr_picker (
    .i_req        (bus.req),
    .i_last_owner (r_last_owner),
    .o_found      (w_pick_found),
    .o_index      (w_pick_idx)
  );

  // Next-state, grant, ownership and watchdog decisions.
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_owner_nxt      = r_owner;
    w_last_owner_nxt = r_last_owner;
    w_abort_set      = 1'b0;
    w_wd_nxt         = '0;
    case (r_state)
      ST_IDLE: begin
        w_grant_nxt = '0;
        if (w_pick_found) begin
          w_grant_nxt = N_MASTERS'(1) << w_pick_idx;
          w_owner_nxt = w_pick_idx;
          w_state_nxt = ST_GRANTED;
        end
      end
      ST_GRANTED: begin
        if (!w_owner_req && !w_active) begin
          w_grant_nxt      = '0;
          w_last_owner_nxt = r_owner;
          w_state_nxt      = ST_IDLE;
        end else if (w_active && !bus.fc_bus) begin
          // Completion on the expiry cycle wins because fc_bus gates this branch.
          if (w_expire) begin
            w_abort_set = 1'b1;
            w_state_nxt = ST_ABORT;
          end else begin
            w_wd_nxt = w_wd_inc;
          end
        end
      end
      ST_ABORT: begin
        // Owner stays granted; release is only evaluated back in GRANTED.
        if (!w_active) begin
          w_state_nxt = ST_GRANTED;
        end
      end
      default: begin
        w_grant_nxt = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, grant, ownership and watchdog registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_owner      <= '0;
      r_last_owner <= OWNER_W'(N_MASTERS - 1);
      r_wd         <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_wd         <= w_wd_nxt;
    end
  end

  // Sticky error flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err        <= 1'b0;
      r_err_master <= '0;
    end else if (w_abort_set) begin
      r_err        <= 1'b1;
      r_err_master <= r_owner;
    end else if (bus.err_clr) begin
      r_err        <= 1'b0;
    end
  end

  assign bus.grant      = r_grant;
  assign bus.fc_timeout = (r_state == ST_ABORT) && w_active;
  assign bus.err        = r_err;
  assign bus.err_master = r_err_master;

endmodule : bus_arbiter

// File: tb/tb_bus_arbiter.sv
// Directed bench for the shared-bus arbiter with hand-computed expectations.
// Latency: inputs driven 1ns after the rising edge, outputs checked there too.
// Backpressure: not applicable.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bus_arbiter_if #(.N_MASTERS(4)) bus ();

  bus_arbiter #(
    .N_MASTERS      (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_g;
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    bus.req         = '0;
    bus.rd_bus      = 1'b0;
    bus.wr_bus      = 1'b0;
    bus.fc_bus      = 1'b0;
    bus.err_clr     = 1'b0;

    // Reset state
    cyc(2);
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_fc_timeout", 32'(bus.fc_timeout), 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    chk("rst_err_master", 32'(bus.err_master), 32'h0);
    rst = 1'b0;
    cyc(1);
    chk("idle_no_req", 32'(bus.grant), 32'h0);

    // Basic grant, turnaround, next grant
    bus.req = 4'b0110;
    cyc(1);
    chk("first_grant", 32'(bus.grant), 32'h2);
    bus.req = 4'b0100;
    cyc(1);
    chk("turnaround", 32'(bus.grant), 32'h0);
    cyc(1);
    chk("second_grant", 32'(bus.grant), 32'h4);
    bus.req = 4'b0000;
    cyc(2);
    chk("all_released", 32'(bus.grant), 32'h0);

    // Round-robin with all masters requesting, from fresh reset
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      cyc(1);
      chk("rr_grant", 32'(bus.grant), 32'(exp_g));
      bus.rd_bus = 1'b1;
      bus.fc_bus = 1'b1;
      cyc(1);
      chk("rr_hold_xfer", 32'(bus.grant), 32'(exp_g));
      bus.rd_bus = 1'b0;
      bus.fc_bus = 1'b0;
      bus.req    = 4'b1111 & ~exp_g;
      cyc(1);
      chk("rr_turnaround", 32'(bus.grant), 32'h0);
      bus.req = 4'b1111;
    end
    bus.req = 4'b0000;

    // Owner drops req mid-read: grant held until transfer ends
    bus.req = 4'b0010;
    cyc(1);
    chk("rd_grant", 32'(bus.grant), 32'h2);
    bus.rd_bus = 1'b1;
    bus.req    = 4'b0000;
    cyc(3);
    chk("rd_held", 32'(bus.grant), 32'h2);
    bus.fc_bus = 1'b1;
    cyc(1);
    chk("rd_held_fc", 32'(bus.grant), 32'h2);
    bus.rd_bus = 1'b0;
    bus.fc_bus = 1'b0;
    cyc(1);
    chk("rd_released", 32'(bus.grant), 32'h0);

    // Watchdog timeout on master 2
    bus.req = 4'b0100;
    cyc(1);
    chk("wd_grant", 32'(bus.grant), 32'h4);
    bus.wr_bus = 1'b1;
    cyc(7);
    chk("wd_pre_fc_timeout", 32'(bus.fc_timeout), 32'h0);
    chk("wd_pre_err", 32'(bus.err), 32'h0);
    cyc(1);
    chk("wd_fc_timeout", 32'(bus.fc_timeout), 32'h1);
    chk("wd_err", 32'(bus.err), 32'h1);
    chk("wd_err_master", 32'(bus.err_master), 32'h2);
    chk("wd_grant_kept", 32'(bus.grant), 32'h4);
    bus.wr_bus = 1'b0;
    #1;
    chk("wd_fc_timeout_drop", 32'(bus.fc_timeout), 32'h0);
    cyc(1);
    chk("wd_back_granted", 32'(bus.grant), 32'h4);
    bus.err_clr = 1'b1;
    cyc(1);
    bus.err_clr = 1'b0;
    chk("err_cleared", 32'(bus.err), 32'h0);

    // Completion on the expiry cycle wins
    bus.wr_bus = 1'b1;
    cyc(7);
    bus.fc_bus = 1'b1;
    cyc(1);
    bus.fc_bus = 1'b0;
    chk("race_fc_timeout", 32'(bus.fc_timeout), 32'h0);
    chk("race_err", 32'(bus.err), 32'h0);

    // Set beats clear; req drop during abort releases only after GRANTED
    cyc(7);
    bus.err_clr = 1'b1;
    cyc(1);
    bus.err_clr = 1'b0;
    chk("setwins_err", 32'(bus.err), 32'h1);
    chk("setwins_fc_timeout", 32'(bus.fc_timeout), 32'h1);
    bus.wr_bus = 1'b0;
    bus.req    = 4'b0000;
    cyc(1);
    chk("abort_exit_held", 32'(bus.grant), 32'h4);
    cyc(1);
    chk("abort_then_release", 32'(bus.grant), 32'h0);
    chk("err_sticky", 32'(bus.err), 32'h1);

    // Second timeout overwrites err_master
    bus.req = 4'b1000;
    cyc(1);
    chk("m3_grant", 32'(bus.grant), 32'h8);
    bus.wr_bus = 1'b1;
    cyc(8);
    chk("overwrite_err_master", 32'(bus.err_master), 32'h3);
    chk("overwrite_err", 32'(bus.err), 32'h1);

    // Asynchronous reset mid-transfer
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_grant", 32'(bus.grant), 32'h0);
    chk("async_rst_err", 32'(bus.err), 32'h0);
    bus.wr_bus = 1'b0;
    bus.req    = 4'b0000;
    cyc(1);
    rst     = 1'b0;
    bus.req = 4'b1001;
    cyc(1);
    chk("post_rst_grant", 32'(bus.grant), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_bus_arbiter

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter N_MASTERS, default 4, the number of bus masters (2..8) sharing addr_bus/data_bus/rd_bus/wr_bus/data_mask_bus/fc_bus.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, the number of cycles a transfer may wait for fc_bus before being aborted (1..65535).
REQ-003 Port clk, input, 1, system clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1, reset; asynchronous, active-high.
REQ-005 Port req, input, N_MASTERS, bit i is the bus_req of master i, level-sensitive.
REQ-006 Port grant, output, N_MASTERS, bit i is the bus_grant to master i; registered, at most one bit set.
REQ-007 Port rd_bus, input, 1, the shared read strobe, observed only.
REQ-008 Port wr_bus, input, 1, the shared write strobe, observed only.
REQ-009 Port fc_bus, input, 1, the slave function-complete, observed only.
REQ-010 Port fc_timeout, output, 1, the completion substitute; the system ORs it into fc_bus.
REQ-011 Port err, output, 1, the sticky timeout flag.
REQ-012 Port err_master, output, 3, the index of the master owning the bus at the last timeout.
REQ-013 Port err_clr, input, 1, a one-cycle pulse that clears err.

Function
REQ-014 The arbiter SHALL implement states IDLE, GRANTED and ABORT.
REQ-015 In IDLE with req != 0, the arbiter SHALL grant one master by round-robin, searching from (last_owner+1) mod N_MASTERS upward with wrap; grant is visible the cycle after req is sampled, and the state becomes GRANTED.
REQ-016 In IDLE with req == 0, grant SHALL stay 0.
REQ-017 In GRANTED, grant SHALL be held while req[owner]=1, or while rd_bus or wr_bus is 1, so a transfer in flight is never revoked.
REQ-018 In GRANTED, when req[owner]=0, rd_bus=0 and wr_bus=0, grant SHALL drop at the next edge, last_owner SHALL be set to owner, and the state SHALL return to IDLE.
REQ-019 The IDLE cycle after any release is a mandatory turnaround cycle with no grant; back-to-back grant changes without it are forbidden.
REQ-020 Requests from non-owners in GRANTED SHALL be ignored; they are neither latched nor lost, since req is a level.
REQ-021 A 16-bit watchdog counter SHALL clear whenever (rd_bus|wr_bus)=0 or fc_bus=1, and SHALL increment each cycle in GRANTED while (rd_bus|wr_bus)=1 and fc_bus=0.
REQ-022 When the watchdog reaches TIMEOUT_CYCLES, the state SHALL become ABORT, err SHALL be set, and err_master SHALL capture owner.
REQ-023 In ABORT, fc_timeout SHALL be 1 while (rd_bus|wr_bus)=1; when both are 0, fc_timeout SHALL be 0 and the state SHALL return to GRANTED with the watchdog cleared.
REQ-024 fc_timeout SHALL be 0 in all states other than ABORT.
REQ-025 If fc_bus=1 in the same cycle the watchdog would expire, completion SHALL win: no abort and no err.
REQ-026 If err_clr=1 in the same cycle a new timeout sets err, the set SHALL win.
REQ-027 If err is already set when a new timeout occurs, err_master SHALL be overwritten with the new owner.
REQ-028 If req[owner] drops during ABORT, the release SHALL occur only after GRANTED is re-entered, per REQ-018.

Reset
REQ-029 On rst: state=IDLE, grant=0, fc_timeout=0, err=0, err_master=0, watchdog=0, last_owner=N_MASTERS-1 (so master 0 has first priority).
REQ-030 rst asserted mid-transfer SHALL drop grant immediately (asynchronously); in-flight transfers are not completed.

Structure
REQ-031 The state encodings SHALL live in a shared include file alongside the CPU state definitions.
REQ-032 Round-robin selection SHALL be a combinational sub-module bus_arbiter_rr_picker (inputs req and last_owner; outputs found and index).
REQ-033 The watchdog and err logic SHALL be in the top module.

Verification
REQ-034 Reset, then req=4'b0110 -> grant=4'b0010 one cycle later; drop req[1] -> grant=0 for one cycle, then grant=4'b0100.
REQ-035 req=4'b1111 held, each owner releases for one cycle after a one-word transfer -> grant order 0,1,2,3,0.
REQ-036 Owner drops req while rd_bus=1 -> grant held until fc_bus=1 and rd_bus=0, then released.
REQ-037 TIMEOUT_CYCLES=8, master 2 asserts wr_bus with no fc_bus -> after 8 cycles fc_timeout=1, err=1, err_master=2; wr_bus drops -> fc_timeout=0; err_clr -> err=0.
REQ-038 fc_bus arrives on the expiry cycle -> no abort and err=0.
REQ-039 rst pulsed while grant=4'b1000 -> grant=0 asynchronously; after reset, req=4'b1001 -> grant=4'b0001.
